// File: rtl/apb_reg_completer_if.sv
// APB bus bundle between our APB master and the apb_reg_completer register bank.
// The master holds PSEL/PADDR/PWRITE/PWDATA from setup until it sees PREADY=1 in the access phase (PENABLE=1).
interface apb_reg_completer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_reg_completer.sv
// APB completer: CTRL/STATUS/SCRATCH register bank with programmable wait states.
// Define APB_COMPLETER_PSLVERR_EN to return PSLVERR on out-of-range accesses and STATUS writes.
module apb_reg_completer #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  apb_reg_completer_if.slave apb,
  input  logic [DATA_W-1:0]  status_in,
  output logic [DATA_W-1:0]  ctrl_out,
  output logic [1:0]         o_dbg_state
);

  localparam int                IDX_W      = $clog2(NUM_REGS);
  localparam logic [3:0]        WAIT_INIT  = 4'(WAIT_CYCLES);
  localparam logic [IDX_W-1:0]  CTRL_IDX   = '0;
  localparam logic [IDX_W-1:0]  STATUS_IDX = IDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;

  logic [IDX_W-1:0]  r_idx;
  logic              r_oor;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              r_pready;
  logic              r_pslverr;
  logic [DATA_W-1:0] r_prdata;

  logic              w_setup;
  logic              w_access_ok;
  logic              w_enter_done;
  logic              w_commit;
  logic              w_err;
  logic [IDX_W-1:0]  w_bus_idx;
  logic              w_bus_oor;
  logic [IDX_W-1:0]  w_idx_sel;
  logic              w_oor_sel;
  logic              w_write_sel;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  assign w_setup     = apb.PSEL & ~apb.PENABLE;
  assign w_access_ok = apb.PSEL &  apb.PENABLE;
  assign w_bus_idx   = apb.PADDR[2 +: IDX_W];
  assign w_bus_oor   = (apb.PADDR >> (IDX_W + 2)) != '0;
  assign w_unused    = ^apb.PADDR[1:0];

  // FSM next state; PSEL/PENABLE loss during WAIT or DONE aborts the transfer.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          if (WAIT_CYCLES == 0) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!w_access_ok) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == 4'd1) begin
          w_state_next = S_DONE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt - 4'd1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // With zero wait states DONE is entered straight from setup, before the latches load.
  assign w_idx_sel   = (r_state == S_IDLE) ? w_bus_idx   : r_idx;
  assign w_oor_sel   = (r_state == S_IDLE) ? w_bus_oor   : r_oor;
  assign w_write_sel = (r_state == S_IDLE) ? apb.PWRITE  : r_write;

  assign w_enter_done = (w_state_next == S_DONE);

  always_comb begin
    w_rdata = '0;
    if (!w_write_sel && !w_oor_sel) begin
      if (w_idx_sel == STATUS_IDX) w_rdata = status_in;
      else                         w_rdata = r_regs[w_idx_sel];
    end
  end

`ifdef APB_COMPLETER_PSLVERR_EN
  assign w_err = w_oor_sel | (w_write_sel & (w_idx_sel == STATUS_IDX));
`else
  assign w_err = 1'b0;
`endif

  assign w_commit = (r_state == S_DONE) & w_access_ok & r_write & ~r_oor &
                    (r_idx != STATUS_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_oor     <= 1'b0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_setup) begin
        r_idx   <= w_bus_idx;
        r_oor   <= w_bus_oor;
        r_write <= apb.PWRITE;
        r_wdata <= apb.PWDATA;
      end
      r_pready  <= w_enter_done;
      r_pslverr <= w_enter_done & w_err;
      r_prdata  <= w_enter_done ? w_rdata : '0;
      if (w_commit) r_regs[r_idx] <= r_wdata;
    end
  end

  assign apb.PREADY  = r_pready;
  assign apb.PSLVERR = r_pslverr;
  assign apb.PRDATA  = r_prdata;
  assign ctrl_out    = r_regs[CTRL_IDX];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Bench for apb_reg_completer: one instance with one wait state and one with none, both on the same bus stimulus.
// A register-map model written from the address-map rules supplies the expected values.
module tb_apb_reg_completer;

  localparam int NREG = 16;
  localparam int W1   = 1;
`ifdef APB_COMPLETER_PSLVERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] status_in;
  logic [31:0] t_paddr, t_pwdata;
  logic        t_pwrite, t_psel, t_penable;
  logic [31:0] ctrl1, ctrl0;
  logic [1:0]  dbg1, dbg0;

  apb_reg_completer_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  apb_reg_completer_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

  assign bus1.PADDR = t_paddr;   assign bus0.PADDR = t_paddr;
  assign bus1.PWRITE = t_pwrite; assign bus0.PWRITE = t_pwrite;
  assign bus1.PSEL = t_psel;     assign bus0.PSEL = t_psel;
  assign bus1.PENABLE = t_penable; assign bus0.PENABLE = t_penable;
  assign bus1.PWDATA = t_pwdata; assign bus0.PWDATA = t_pwdata;

  apb_reg_completer #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(NREG), .WAIT_CYCLES(W1)) dut (
    .clk(clk), .rst_n(rst_n), .apb(bus1), .status_in(status_in),
    .ctrl_out(ctrl1), .o_dbg_state(dbg1));

  apb_reg_completer #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(NREG), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .apb(bus0), .status_in(status_in),
    .ctrl_out(ctrl0), .o_dbg_state(dbg0));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_regs [NREG];

  // reference model
  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int idx;
    if (addr >= NREG * 4) return 32'h0;
    idx = int'(addr / 4);
    if (idx == 1) return status_in;
    return model_regs[idx];
  endfunction

  function automatic logic model_err(input logic [31:0] addr, input logic wr);
    return ERR_EN && ((addr >= NREG * 4) || (wr && (addr / 4 == 1)));
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
    if (addr < NREG * 4 && addr / 4 != 1) model_regs[int'(addr / 4)] = data;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) model_regs[i] = 32'h0;
  endtask

  // driver tasks
  task automatic bus_idle(input int n);
    @(posedge clk); #1;
    t_psel = 1'b0; t_penable = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          output logic [31:0] rd1, output logic e1, output int lat1,
                          output logic [31:0] rd0, output logic e0, output int lat0,
                          output logic leak);
    int k;
    rd1 = '0; e1 = 1'b0; lat1 = -1; rd0 = '0; e0 = 1'b0; lat0 = -1; leak = 1'b0;
    @(posedge clk); #1;
    t_psel = 1'b1; t_penable = 1'b0; t_paddr = addr; t_pwrite = wr; t_pwdata = wdata;
    @(posedge clk); #1;
    t_penable = 1'b1;
    k = 0;
    while (lat1 < 0 && k < 20) begin
      @(negedge clk);
      k++;
      if (bus0.PREADY && lat0 < 0) begin
        lat0 = k; rd0 = bus0.PRDATA; e0 = bus0.PSLVERR;
      end else if (!bus0.PREADY && (bus0.PRDATA != 0 || bus0.PSLVERR)) leak = 1'b1;
      if (bus1.PREADY) begin
        lat1 = k; rd1 = bus1.PRDATA; e1 = bus1.PSLVERR;
      end else if (bus1.PRDATA != 0 || bus1.PSLVERR) leak = 1'b1;
    end
  endtask

  // one transfer checked against the model on both instances
  task automatic checked_xfer(input string name, input logic [31:0] addr, input logic wr,
                              input logic [31:0] wdata);
    logic [31:0] rd1, rd0, exp_rd;
    logic e1, e0, exp_e, leak;
    int lat1, lat0;
    exp_rd = model_read(addr);
    exp_e  = model_err(addr, wr);
    apb_xfer(addr, wr, wdata, rd1, e1, lat1, rd0, e0, lat0, leak);
    if (wr) model_write(addr, wdata);
    n_cmp++; if (lat1 !== 1 + W1) begin n_bad++; $display("FAIL %s latency_w1 addr=%h got=%0d exp=%0d", name, addr, lat1, 1 + W1); end
    n_cmp++; if (lat0 !== 1) begin n_bad++; $display("FAIL %s latency_w0 addr=%h got=%0d exp=1", name, addr, lat0); end
    n_cmp++; if (e1 !== exp_e) begin n_bad++; $display("FAIL %s pslverr_w1 addr=%h got=%b exp=%b", name, addr, e1, exp_e); end
    n_cmp++; if (e0 !== exp_e) begin n_bad++; $display("FAIL %s pslverr_w0 addr=%h got=%b exp=%b", name, addr, e0, exp_e); end
    n_cmp++; if (leak !== 1'b0) begin n_bad++; $display("FAIL %s prdata_idle addr=%h got=nonzero exp=0", name, addr); end
    if (!wr) begin
      n_cmp++; if (rd1 !== exp_rd) begin n_bad++; $display("FAIL %s prdata_w1 addr=%h got=%h exp=%h", name, addr, rd1, exp_rd); end
      n_cmp++; if (rd0 !== exp_rd) begin n_bad++; $display("FAIL %s prdata_w0 addr=%h got=%h exp=%h", name, addr, rd0, exp_rd); end
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus1.PREADY !== 1'b0 || bus0.PREADY !== 1'b0) begin n_bad++; $display("FAIL reset_pready got=%b/%b exp=0/0", bus1.PREADY, bus0.PREADY); end
    n_cmp++; if (bus1.PRDATA !== 32'h0 || bus0.PRDATA !== 32'h0) begin n_bad++; $display("FAIL reset_prdata got=%h/%h exp=0", bus1.PRDATA, bus0.PRDATA); end
    n_cmp++; if (bus1.PSLVERR !== 1'b0 || bus0.PSLVERR !== 1'b0) begin n_bad++; $display("FAIL reset_pslverr got=%b/%b exp=0/0", bus1.PSLVERR, bus0.PSLVERR); end
    n_cmp++; if (ctrl1 !== 32'h0 || ctrl0 !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl got=%h/%h exp=0", ctrl1, ctrl0); end
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_ctrl();
    checked_xfer("ctrl_wr", 32'h0, 1'b1, 32'hDEADBEEF);
    bus_idle(1);
    @(negedge clk);
    n_cmp++; if (ctrl1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ctrl_out_w1 got=%h exp=deadbeef", ctrl1); end
    n_cmp++; if (ctrl0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ctrl_out_w0 got=%h exp=deadbeef", ctrl0); end
    checked_xfer("ctrl_rd", 32'h0, 1'b0, 32'h0);
    bus_idle(2);
  endtask

  task automatic test_status();
    status_in = 32'h1234;
    checked_xfer("status_rd", 32'h4, 1'b0, 32'h0);
    checked_xfer("status_wr", 32'h4, 1'b1, 32'h55);
    checked_xfer("status_rd2", 32'h4, 1'b0, 32'h0);
    status_in = $urandom;
    checked_xfer("status_rd3", 32'h4, 1'b0, 32'h0);
    bus_idle(1);
  endtask

  task automatic test_back_to_back();
    checked_xfer("b2b_wr", 32'h8, 1'b1, 32'hA5A5A5A5);
    checked_xfer("b2b_rd", 32'h8, 1'b0, 32'h0);
    checked_xfer("b2b_wr_last", 32'h3C, 1'b1, 32'h0BADF00D);
    checked_xfer("b2b_rd_last", 32'h3C, 1'b0, 32'h0);
    checked_xfer("b2b_rd_lowbits", 32'h0B, 1'b0, 32'h0);
    bus_idle(1);
  endtask

  task automatic test_out_of_range();
    checked_xfer("oor_rd", 32'h40, 1'b0, 32'h0);
    checked_xfer("oor_wr", 32'h44, 1'b1, 32'hFFFFFFFF);
    checked_xfer("oor_rd_far", 32'h8000_0000, 1'b0, 32'h0);
    for (int i = 0; i < NREG; i++) checked_xfer("oor_sweep", 32'(i * 4), 1'b0, 32'h0);
    bus_idle(1);
  endtask

  task automatic test_abort();
    checked_xfer("abort_pre", 32'h10, 1'b1, 32'h11112222);
    @(posedge clk); #1;
    t_psel = 1'b1; t_penable = 1'b0; t_paddr = 32'h10; t_pwrite = 1'b1; t_pwdata = 32'h99999999;
    @(posedge clk); #1;
    t_psel = 1'b0; t_penable = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++; if (bus1.PREADY !== 1'b0) begin n_bad++; $display("FAIL abort_pready_w1 cyc=%0d got=%b exp=0", k, bus1.PREADY); end
      if (k >= 2) begin
        n_cmp++; if (bus0.PREADY !== 1'b0) begin n_bad++; $display("FAIL abort_pready_w0 cyc=%0d got=%b exp=0", k, bus0.PREADY); end
      end
    end
    @(posedge clk); #1;
    t_psel = 1'b1; t_penable = 1'b1; t_paddr = 32'h10; t_pwrite = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++; if (bus1.PREADY !== 1'b0 || bus0.PREADY !== 1'b0) begin n_bad++; $display("FAIL no_setup_pready cyc=%0d got=%b/%b exp=0/0", k, bus1.PREADY, bus0.PREADY); end
    end
    bus_idle(1);
    checked_xfer("abort_rd", 32'h10, 1'b0, 32'h0);
    bus_idle(1);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    t_psel = 1'b1; t_penable = 1'b0; t_paddr = 32'hC; t_pwrite = 1'b1; t_pwdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    t_penable = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus1.PREADY !== 1'b0 || bus0.PREADY !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pready got=%b/%b exp=0/0", bus1.PREADY, bus0.PREADY); end
    t_psel = 1'b0; t_penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    n_cmp++; if (ctrl1 !== 32'h0 || ctrl0 !== 32'h0) begin n_bad++; $display("FAIL rst_mid_ctrl got=%h/%h exp=0", ctrl1, ctrl0); end
    checked_xfer("rst_mid_rd_c", 32'hC, 1'b0, 32'h0);
    checked_xfer("rst_mid_rd_8", 32'h8, 1'b0, 32'h0);
    bus_idle(1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        wr;
    for (int n = 0; n < 80; n++) begin
      status_in = $urandom;
      a  = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      checked_xfer("rand", a, wr, $urandom);
      if ($urandom_range(0, 3) == 0) bus_idle($urandom_range(1, 3));
    end
    bus_idle(1);
    @(negedge clk);
    n_cmp++; if (ctrl1 !== model_regs[0] || ctrl0 !== model_regs[0]) begin n_bad++; $display("FAIL rand_ctrl got=%h/%h exp=%h", ctrl1, ctrl0, model_regs[0]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    t_psel = 1'b0; t_penable = 1'b0; t_paddr = '0; t_pwrite = 1'b0; t_pwdata = '0;
    status_in = '0;
    test_reset();
    test_ctrl();
    test_status();
    test_back_to_back();
    test_out_of_range();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
